// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer
//   Multi-cycle fetch/decode/execute/writeback controller for the alu_basica
//   ALU. One instruction takes FETCH, DECODE, EXEC, WAIT, WB (5 cycles with a
//   zero-wait instruction memory).
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an instruction the ALU does not accept (no alu_result_valid in
//               WAIT) stops the core in TRAP with pc left on that instruction.
//   undefined : the instruction retires as a NOP (no write, pc+4).
//
// Ports
//   clk, resetn              clock / asynchronous active-low reset
//   start, halt_req          run control (start sampled only in IDLE)
//   imem_req/addr/ready/rdata  instruction fetch handshake (addr = pc)
//   rf_raddr1/2, rf_rdata1/2   register file read (combinational data)
//   rf_we/waddr/wdata          register file write, one-cycle strobe in WB
//   alu_valid + operands       one-cycle ALU issue
//   alu_result/next_pc/result_valid/is_jump  ALU response, one cycle after issue
//   pc, busy, trap, retired    architectural status
module alu_exec_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        alu_valid,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_rs1_data,
  output logic [31:0] alu_rs2_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_next_pc,
  input  logic        alu_result_valid,
  input  logic        alu_is_jump,
  output logic [31:0] pc,
  output logic        busy,
  output logic        trap,
  output logic [31:0] retired
);

  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_TRAP
  } state_t;

  state_t        state_q;
  logic [31:0]   pc_q, instr_q, rs1_q, rs2_q, result_q, next_pc_q, retired_q;
  logic [TW-1:0] tmo_q;
  logic          halt_q, imem_req_q, alu_valid_q, rf_we_q, busy_q, trap_q;

  logic [31:0]   pc_plus4_d;
  logic          halt_d;
  logic          unused_jump;

  assign pc_plus4_d = pc_q + 32'd4;
  // A halt request arriving in the WB cycle itself still stops the core.
  assign halt_d     = halt_q | halt_req;
  // Jump flag is informational; next-pc already carries the target.
  assign unused_jump = alu_is_jump;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      result_q    <= '0;
      next_pc_q   <= '0;
      retired_q   <= '0;
      tmo_q       <= '0;
      halt_q      <= 1'b0;
      imem_req_q  <= 1'b0;
      alu_valid_q <= 1'b0;
      rf_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      // One-cycle strobes fall back to 0 unless re-armed below.
      alu_valid_q <= 1'b0;
      rf_we_q     <= 1'b0;

      if (state_q != S_IDLE && state_q != S_TRAP && halt_req)
        halt_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
            tmo_q      <= '0;
            halt_q     <= halt_req;
          end
        end

        S_FETCH: begin
          if (imem_ready) begin
            instr_q    <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (tmo_q == TMO_LAST) begin
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            trap_q     <= 1'b1;
            state_q    <= S_TRAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_DECODE: begin
          rs1_q       <= rf_rdata1;
          rs2_q       <= rf_rdata2;
          alu_valid_q <= 1'b1;
          state_q     <= S_EXEC;
        end

        S_EXEC: state_q <= S_WAIT;

        S_WAIT: begin
          if (alu_result_valid) begin
            result_q  <= alu_result;
            next_pc_q <= alu_next_pc;
            rf_we_q   <= (instr_q[11:7] != 5'd0);
            state_q   <= S_WB;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            busy_q  <= 1'b0;
            trap_q  <= 1'b1;
            state_q <= S_TRAP;
`else
            // Unsupported opcode retires as a NOP.
            result_q  <= '0;
            next_pc_q <= pc_plus4_d;
            state_q   <= S_WB;
`endif
          end
        end

        S_WB: begin
          pc_q      <= next_pc_q;
          retired_q <= retired_q + 32'd1;
          if (halt_d) begin
            halt_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            imem_req_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_FETCH;
          end
        end

        S_TRAP: ; // leaves only through reset

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req        = imem_req_q;
  assign imem_addr       = pc_q;
  assign rf_raddr1       = instr_q[19:15];
  assign rf_raddr2       = instr_q[24:20];
  assign rf_we           = rf_we_q;
  assign rf_waddr        = instr_q[11:7];
  assign rf_wdata        = result_q;
  assign alu_valid       = alu_valid_q;
  assign alu_instruction = instr_q;
  assign alu_pc          = pc_q;
  assign alu_rs1_data    = rs1_q;
  assign alu_rs2_data    = rs2_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign trap            = trap_q;
  assign retired         = retired_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with behavioural imem, regfile and a
// one-cycle-latency ALU model.
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        resetn, start, halt_req;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we, alu_valid;
  logic [31:0] alu_instruction, alu_pc, alu_rs1_data, alu_rs2_data;
  logic [31:0] alu_result, alu_next_pc;
  logic        alu_result_valid, alu_is_jump;
  logic [31:0] pc, retired;
  logic        busy, trap;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic        ready_en;
  logic [31:0] imem [64];
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  alu_exec_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_valid(alu_valid), .alu_instruction(alu_instruction), .alu_pc(alu_pc),
    .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
    .alu_result(alu_result), .alu_next_pc(alu_next_pc),
    .alu_result_valid(alu_result_valid), .alu_is_jump(alu_is_jump),
    .pc(pc), .busy(busy), .trap(trap), .retired(retired)
  );

  // Instruction memory: zero-wait when enabled.
  assign imem_ready = imem_req & ready_en;
  assign imem_rdata = imem[imem_addr[7:2]];

  // Register file: combinational read, write on clock edge.
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[1] <= 32'd5;
      regs[2] <= 32'd3;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // ALU model: add/sub/and/or/xor (R-type) and jal, result one cycle after issue.
  logic [31:0] m_res, m_npc, jimm;
  logic        m_valid, m_jump;
  always_comb begin
    m_valid = 1'b0;
    m_jump  = 1'b0;
    m_res   = 32'd0;
    m_npc   = alu_pc + 32'd4;
    jimm    = {{11{alu_instruction[31]}}, alu_instruction[31], alu_instruction[19:12],
               alu_instruction[20], alu_instruction[30:21], 1'b0};
    if (alu_instruction[6:0] == 7'h33) begin
      m_valid = 1'b1;
      case (alu_instruction[14:12])
        3'd0: m_res = (alu_instruction[31:25] == 7'h20) ? alu_rs1_data - alu_rs2_data
                                                        : alu_rs1_data + alu_rs2_data;
        3'd4: m_res = alu_rs1_data ^ alu_rs2_data;
        3'd6: m_res = alu_rs1_data | alu_rs2_data;
        3'd7: m_res = alu_rs1_data & alu_rs2_data;
        default: m_valid = 1'b0;
      endcase
    end else if (alu_instruction[6:0] == 7'h6F) begin
      m_valid = 1'b1;
      m_jump  = 1'b1;
      m_res   = alu_pc + 32'd4;
      m_npc   = alu_pc + jimm;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_result_valid <= 1'b0;
      alu_is_jump      <= 1'b0;
      alu_result       <= 32'd0;
      alu_next_pc      <= 32'd0;
    end else begin
      alu_result_valid <= alu_valid & m_valid;
      alu_is_jump      <= alu_valid & m_jump;
      alu_result       <= m_res;
      alu_next_pc      <= m_npc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-16s observed %h expected %h", tag, obs, exp);
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ticks(2);
    resetn = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    halt_req = 1'b0;
    ready_en = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    imem[0] = 32'h0020_81B3;  // add x3,x1,x2
    imem[1] = 32'h4020_8233;  // sub x4,x1,x2
    imem[2] = 32'h0020_C2B3;  // xor x5,x1,x2
    do_reset();

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_strobes", {29'd0, imem_req, rf_we, alu_valid}, 32'd0);

    // 1: add with start+halt together -> exactly one instruction
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    chk("t1_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("t1_fetch_addr", imem_addr, 32'h0);
    ticks(2);  // DECODE, EXEC
    chk("t1_alu_valid", {31'd0, alu_valid}, 32'd1);
    chk("t1_rs1", alu_rs1_data, 32'd5);
    chk("t1_rs2", alu_rs2_data, 32'd3);
    chk("t1_instr", alu_instruction, 32'h0020_81B3);
    tick();    // WAIT
    chk("t1_alu_pulse", {31'd0, alu_valid}, 32'd0);
    chk("t1_we_early", {31'd0, rf_we}, 32'd0);
    tick();    // WB, cycle 5
    chk("t1_we", {31'd0, rf_we}, 32'd1);
    chk("t1_wdata", rf_wdata, 32'd8);
    chk("t1_waddr", {27'd0, rf_waddr}, 32'd3);
    tick();
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_pc", pc, 32'd4);
    chk("t1_retired", retired, 32'd1);
    chk("t1_we_off", {31'd0, rf_we}, 32'd0);
    chk("t1_x3", regs[3], 32'd8);

    // halt_req in IDLE has no lasting effect; start ignored paths tested below
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("idle_halt", {31'd0, busy}, 32'd0);

    // 2: sub then xor back to back; halt pulse during second EXEC
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);  // WB of sub
    chk("t2_sub_we", {31'd0, rf_we}, 32'd1);
    chk("t2_sub_wdata", rf_wdata, 32'd2);
    chk("t2_sub_waddr", {27'd0, rf_waddr}, 32'd4);
    tick();    // FETCH pc=8
    chk("t2_fetch_addr", imem_addr, 32'd8);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    ticks(2);  // EXEC of xor
    halt_req = 1'b1;
    tick();    // WAIT
    halt_req = 1'b0;
    tick();    // WB
    chk("t2_xor_wdata", rf_wdata, 32'd6);
    chk("t2_xor_waddr", {27'd0, rf_waddr}, 32'd5);
    tick();
    chk("t2_halt_idle", {31'd0, busy}, 32'd0);
    chk("t2_retired", retired, 32'd3);
    chk("t2_pc", pc, 32'd12);

    // 3: jal x1,+16 at pc=8, then jal x0,-8 at pc=24
    do_reset();
    chk("t3_rst_pc", pc, 32'h0);
    chk("t3_rst_ret", retired, 32'd0);
    imem[0] = 32'h0000_0033;  // add x0,x0,x0
    imem[1] = 32'h0000_0033;
    imem[2] = 32'h0100_00EF;  // jal x1,+16
    imem[6] = 32'hFF9F_F06F;  // jal x0,-8
    imem[4] = 32'h0000_0013;  // addi x0,x0,0 (not an ALU op)
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);  // WB of nop
    chk("t3_nop_we", {31'd0, rf_we}, 32'd0);
    ticks(6);  // through nop 2 into FETCH of jal
    chk("t3_jal_addr", imem_addr, 32'd8);
    ticks(4);  // WB of jal x1
    chk("t3_jal_we", {31'd0, rf_we}, 32'd1);
    chk("t3_jal_wdata", rf_wdata, 32'd12);
    chk("t3_jal_waddr", {27'd0, rf_waddr}, 32'd1);
    tick();    // FETCH at target
    chk("t3_jal_pc", pc, 32'd24);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    ticks(3);  // WB of jal x0
    chk("t3_jx0_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("t3_jx0_pc", pc, 32'd16);
    chk("t3_retired", retired, 32'd4);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // 5: illegal (addi) at pc=16
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    ticks(4);
`ifdef ILLEGAL_TRAP_EN
    chk("t5_trap", {31'd0, trap}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_pc", pc, 32'd16);
    chk("t5_retired", retired, 32'd4);
`else
    chk("t5_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("t5_trap", {31'd0, trap}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_pc", pc, 32'd20);
    chk("t5_retired", retired, 32'd5);
`endif

    // 4: fetch timeout
    do_reset();
    ready_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(15);
    chk("t4_still_req", {31'd0, imem_req}, 32'd1);
    chk("t4_no_trap", {31'd0, trap}, 32'd0);
    tick();
    chk("t4_trap", {31'd0, trap}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_req", {31'd0, imem_req}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_sticky", {31'd0, trap}, 32'd1);
    do_reset();
    chk("t4_rst_trap", {31'd0, trap}, 32'd0);

    // 6: asynchronous reset in the middle of a fetch
    ready_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(5);  // FETCH of pc=4
    chk("t6_pc", pc, 32'd4);
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    ready_en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_pc", pc, 32'h0);
    chk("t6_async_req", {31'd0, imem_req}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_ret", retired, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("t6_after_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
